// File: rtl/ram_dma_controller.sv
// CPU-programmed DMA engine that fills RAM from a source stream or a constant pattern.
// Define RAM_DMA_FILL_EN to build in fill mode and the FILL register.
module ram_dma_controller #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_en,
    input  logic [1:0]  reg_address,
    input  logic [3:0]  reg_wstrb,
    input  logic [31:0] reg_write_data,
    output logic [31:0] reg_read_data,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic [15:0] dma_address,
    output logic [31:0] dma_write_data,
    output logic [3:0]  dma_wstrb,
    output logic        dma_busy,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [15:0]           length_q, length_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [31:0]           fill_q, fill_d;
    logic [31:0]           out_data_q, out_data_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;

    logic reg_wr;
    logic ctrl_wr;
    logic is_idle;
    logic start_req;
    logic beat;

    assign reg_wr    = reg_en && (|reg_wstrb);
    assign ctrl_wr   = reg_wr && (reg_address == 2'd3);
    assign is_idle   = (state_q == IDLE);
    assign start_req = is_idle && ctrl_wr && reg_write_data[0];
    assign beat      = (state_q == RUN) && (mode_q || src_valid);

`ifdef RAM_DMA_FILL_EN
    always_comb begin
        fill_d = fill_q;
        mode_d = mode_q;
        if (is_idle && reg_wr && (reg_address == 2'd2)) fill_d = reg_write_data;
        if (is_idle && ctrl_wr) mode_d = reg_write_data[1];
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^reg_write_data[31:16];
    assign fill_d       = 32'h0;
    assign mode_d       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            addr_q      <= '0;
            out_addr_q  <= '0;
            length_q    <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            wstrb_q     <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            addr_q      <= addr_d;
            out_addr_q  <= out_addr_d;
            length_q    <= length_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            wstrb_q     <= wstrb_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

    // ARM holds RAM off until the CPU's start access has left the register window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req && (length_q != 16'd0)) state_d = ARM;
            ARM:     if (!reg_en) state_d = RUN;
            RUN:     if (beat && (remaining_q == 16'd1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dest_d      = dest_q;
        length_d    = length_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        wstrb_d     = 4'h0;
        done_d      = done_q;

        if (is_idle && reg_wr && (reg_address == 2'd0)) dest_d = reg_write_data[ADDR_WIDTH-1:0];
        if (is_idle && reg_wr && (reg_address == 2'd1)) length_d = reg_write_data[15:0];

        if (start_req && (length_q != 16'd0)) begin
            addr_d      = dest_q;
            remaining_d = length_q;
        end

        if (beat) begin
            wstrb_d     = 4'hf;
            out_addr_d  = addr_q;
            out_data_d  = mode_q ? fill_q : src_data;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - 16'd1;
        end

        // A done-set in the same cycle as an ack must win, so it is applied last.
        if (ctrl_wr && reg_write_data[2]) done_d = 1'b0;
        if ((start_req && (length_q == 16'd0)) || (state_q == DONE)) done_d = 1'b1;
    end

    always_comb begin
        dma_busy      = (state_q == RUN) || (state_q == DONE);
        src_ready     = (state_q == RUN) && !mode_q && (remaining_q != 16'd0);
        reg_read_data = 32'h0;
        case (reg_address)
            2'd0: reg_read_data = 32'(dest_q);
            2'd1: reg_read_data = {16'h0, length_q};
            2'd2: reg_read_data = fill_q;
            2'd3: reg_read_data = {remaining_q, 13'h0, mode_q, done_q, !is_idle};
            default: reg_read_data = 32'h0;
        endcase
    end

    assign dma_address    = 16'(out_addr_q);
    assign dma_write_data = out_data_q;
    assign dma_wstrb      = wstrb_q;
    assign irq            = done_q;

endmodule
